control_unit_fsm: RTL and testbench
===================================

CONTROL_UNIT_FSM -- requirements
Module: control_unit_fsm

Interface
REQ-001 SHALL expose: Clk  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL expose: Reset  in  1  synchronous, active-high reset, sampled on Clk rising edge.
REQ-003 SHALL expose: State_Sel  in  7  execute-entry state from instruction encoder (0 = unrecognised).
REQ-004 SHALL expose: MOC  in  1  memory operation complete, level, valid while MOV=1.
REQ-005 SHALL expose: Cond  in  1  ALU zero flag, used by BEQ.
REQ-006 SHALL expose: State  out  7  current state number.
REQ-007 SHALL expose: PC_Ld, IR_Ld, MAR_Ld, MDR_Ld, RF_Ld  out  1 each  register load enables.
REQ-008 SHALL expose: MOV  out  1  memory request; RW  out  1  1=read, 0=write.
REQ-009 SHALL expose: ALU_Op  out  4  0 ADD, 1 SUB, 2 AND, 3 SLTU, 4 CLO, 5 CLZ, 6 PASS_A; Imm_Sel  out  1  ALU B = sign/zero-extended immediate.
REQ-010 SHALL expose: Illegal  out  1  one-cycle pulse on unrecognised instruction.

Function
REQ-011 SHALL be a Moore machine: every output is a pure decode of the State register.
REQ-012 SHALL step 0 RESET -> 1 FETCH0 (MAR_Ld, ALU_Op=PASS_A on PC) -> 2 FETCH1 -> 3 FETCH2 (IR_Ld, PC_Ld, ALU_Op=ADD PC+4) -> 4 DECODE.
REQ-013 SHALL assert MOV=1, RW=1, MDR_Ld=1 in 2; hold 2 while MOC=0; go to 3 on the edge where MOC=1.
REQ-014 SHALL, in 4, load State_Sel when it is in {6,7,11,13,17..24}; any other value, including 0, goes to 5 ILLEGAL.
REQ-015 SHALL assert Illegal only in 5, then go to 1 (instruction treated as NOP).
REQ-016 SHALL treat 6 ADDU, 17 SUBU, 18 ADDIU, 19 SLTU, 20 SLTIU, 21 CLO, 22 CLZ, 23 AND, 24 ANDI as single-cycle: RF_Ld=1, ALU_Op per mnemonic, Imm_Sel=1 for 18/20/24 only, then 1.
REQ-017 SHALL sequence store 7 (MAR_Ld, ADD, Imm_Sel) -> 8 (MDR_Ld) -> 9 (MOV=1, RW=0; hold while MOC=0) -> 1.
REQ-018 SHALL sequence load 13 (MAR_Ld, ADD, Imm_Sel) -> 14 (MOV=1, RW=1, MDR_Ld; hold while MOC=0) -> 15 (RF_Ld) -> 1.
REQ-019 SHALL sequence BEQ 11 (ALU_Op=SUB): Cond=1 -> 12 (PC_Ld, ALU_Op=ADD branch target) -> 1; Cond=0 -> 1.
REQ-020 SHALL send any unused state code (10, 16, 25..127) to 0 on the next edge.
REQ-021 SHALL give no MOV timeout: wait states hold indefinitely.
REQ-022 SHALL sample MOC only in states 2, 9, 14; MOC elsewhere has no effect.
REQ-023 SHALL drive all enables, MOV, RW, Imm_Sel, Illegal = 0 and ALU_Op = 0 in states not listed for that signal.
REQ-024 SHALL accept State_Sel only in DECODE; changes elsewhere have no effect.

Reset
REQ-025 SHALL enter state 0 on any edge with Reset=1, overriding every transition, including mid-memory wait.
REQ-026 SHALL drive, in state 0: State=0, all enables/MOV/Illegal=0, RW=0, ALU_Op=0.
REQ-027 SHALL leave 0 to 1 on the first edge with Reset=0.

Structure
REQ-028 SHALL place state-number constants (0..24) and ALU_Op codes in a shared package, also used by the encoder and ALU.
REQ-029 SHALL split into a next-state register block and one combinational sub-module control_rom mapping State to the control word.

Verification
REQ-030 ADDU word, MOC high one cycle after request -> states 0,1,2,3,4,6,1; RF_Ld high exactly in 6; ALU_Op=0.
REQ-031 LW, MOC delayed 3 cycles in 14 -> 14 held 4 cycles; MDR_Ld high throughout; then 15 with RF_Ld, then 1.
REQ-032 BEQ with Cond=1 -> 11,12,1 with PC_Ld in 12; Cond=0 -> 11,1, no PC_Ld.
REQ-033 State_Sel=0 in DECODE -> state 5, Illegal high 1 cycle, then 1.
REQ-034 Reset=1 in state 9 with MOV=1 -> next edge State=0, MOV=0, RW=0; Reset released -> state 1.
REQ-035 SW with MOC=1 already high on entry to 9 -> 9 lasts one cycle, RW=0, then 1.

Source files
------------

// File: rtl/control_unit_fsm_pkg.sv
// -----------------------------------------------------------------------------
// control_unit_fsm_pkg
// Shared definitions for the multi-cycle control unit, the instruction encoder
// and the ALU:
//   - state_e     : state numbers (0..24) as seen on the State output and on
//                   the encoder's State_Sel output
//   - alu_op_e    : ALU operation codes driven on ALU_Op
//   - ctrl_word_t : decoded control word produced by control_rom
//   - is_exec_entry(): which State_Sel values are legal execute-entry states
// -----------------------------------------------------------------------------
package control_unit_fsm_pkg;

  localparam int unsigned STATE_W = 7;
  localparam int unsigned ALU_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET    = 7'd0,
    ST_FETCH0   = 7'd1,
    ST_FETCH1   = 7'd2,
    ST_FETCH2   = 7'd3,
    ST_DECODE   = 7'd4,
    ST_ILLEGAL  = 7'd5,
    ST_ADDU     = 7'd6,
    ST_SW_ADDR  = 7'd7,
    ST_SW_DATA  = 7'd8,
    ST_SW_MEM   = 7'd9,
    ST_BEQ      = 7'd11,
    ST_BEQ_TAKE = 7'd12,
    ST_LW_ADDR  = 7'd13,
    ST_LW_MEM   = 7'd14,
    ST_LW_WB    = 7'd15,
    ST_SUBU     = 7'd17,
    ST_ADDIU    = 7'd18,
    ST_SLTU     = 7'd19,
    ST_SLTIU    = 7'd20,
    ST_CLO      = 7'd21,
    ST_CLZ      = 7'd22,
    ST_AND      = 7'd23,
    ST_ANDI     = 7'd24
  } state_e;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_SLTU   = 4'd3,
    ALU_CLO    = 4'd4,
    ALU_CLZ    = 4'd5,
    ALU_PASS_A = 4'd6
  } alu_op_e;

  typedef struct packed {
    logic    pc_ld;
    logic    ir_ld;
    logic    mar_ld;
    logic    mdr_ld;
    logic    rf_ld;
    logic    mov;
    logic    rw;       // 1 = read, 0 = write
    alu_op_e alu_op;
    logic    imm_sel;
    logic    illegal;
  } ctrl_word_t;

  // Execute-entry states the encoder is allowed to request from DECODE.
  function automatic logic is_exec_entry(input logic [STATE_W-1:0] sel);
    logic ok;
    ok = 1'b0;
    case (sel)
      ST_ADDU, ST_SW_ADDR, ST_BEQ, ST_LW_ADDR,
      ST_SUBU, ST_ADDIU, ST_SLTU, ST_SLTIU,
      ST_CLO, ST_CLZ, ST_AND, ST_ANDI: ok = 1'b1;
      default:                         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/control_rom.sv
// -----------------------------------------------------------------------------
// control_rom
// Purely combinational decode of the current state number into the control
// word. Any state not named below (including the unused codes) yields an
// all-zero word, which is also the reset-state word.
// Ports:
//   state_i : current state number
//   ctrl_o  : control word (load enables, memory request, ALU select, flags)
// -----------------------------------------------------------------------------
module control_rom
  import control_unit_fsm_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  output ctrl_word_t         ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH0: begin
        ctrl_o.mar_ld = 1'b1;
        ctrl_o.alu_op = ALU_PASS_A;   // MAR <- PC through the ALU
      end
      ST_FETCH1: begin
        ctrl_o.mov    = 1'b1;
        ctrl_o.rw     = 1'b1;
        ctrl_o.mdr_ld = 1'b1;
      end
      ST_FETCH2: begin
        ctrl_o.ir_ld  = 1'b1;
        ctrl_o.pc_ld  = 1'b1;
        ctrl_o.alu_op = ALU_ADD;      // PC + 4
      end
      ST_ILLEGAL: ctrl_o.illegal = 1'b1;
      ST_ADDU: begin
        ctrl_o.rf_ld  = 1'b1;
        ctrl_o.alu_op = ALU_ADD;
      end
      ST_SUBU: begin
        ctrl_o.rf_ld  = 1'b1;
        ctrl_o.alu_op = ALU_SUB;
      end
      ST_ADDIU: begin
        ctrl_o.rf_ld   = 1'b1;
        ctrl_o.alu_op  = ALU_ADD;
        ctrl_o.imm_sel = 1'b1;
      end
      ST_SLTU: begin
        ctrl_o.rf_ld  = 1'b1;
        ctrl_o.alu_op = ALU_SLTU;
      end
      ST_SLTIU: begin
        ctrl_o.rf_ld   = 1'b1;
        ctrl_o.alu_op  = ALU_SLTU;
        ctrl_o.imm_sel = 1'b1;
      end
      ST_CLO: begin
        ctrl_o.rf_ld  = 1'b1;
        ctrl_o.alu_op = ALU_CLO;
      end
      ST_CLZ: begin
        ctrl_o.rf_ld  = 1'b1;
        ctrl_o.alu_op = ALU_CLZ;
      end
      ST_AND: begin
        ctrl_o.rf_ld  = 1'b1;
        ctrl_o.alu_op = ALU_AND;
      end
      ST_ANDI: begin
        ctrl_o.rf_ld   = 1'b1;
        ctrl_o.alu_op  = ALU_AND;
        ctrl_o.imm_sel = 1'b1;
      end
      // Effective address for loads and stores: base + immediate offset.
      ST_SW_ADDR, ST_LW_ADDR: begin
        ctrl_o.mar_ld  = 1'b1;
        ctrl_o.alu_op  = ALU_ADD;
        ctrl_o.imm_sel = 1'b1;
      end
      ST_SW_DATA: ctrl_o.mdr_ld = 1'b1;
      ST_SW_MEM: begin
        ctrl_o.mov = 1'b1;            // rw stays 0: write
      end
      ST_LW_MEM: begin
        ctrl_o.mov    = 1'b1;
        ctrl_o.rw     = 1'b1;
        ctrl_o.mdr_ld = 1'b1;
      end
      ST_LW_WB:  ctrl_o.rf_ld = 1'b1;
      ST_BEQ:    ctrl_o.alu_op = ALU_SUB;   // compare; result only feeds Cond
      ST_BEQ_TAKE: begin
        ctrl_o.pc_ld  = 1'b1;
        ctrl_o.alu_op = ALU_ADD;      // branch target
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/control_unit_fsm.sv
// -----------------------------------------------------------------------------
// control_unit_fsm
// Moore-type multi-cycle control unit. The state register advances through
// fetch, decode and a per-instruction execute sequence; every output is a
// decode of the registered state by control_rom.
// Ports:
//   Clk       : clock, all state changes on the rising edge
//   Reset     : synchronous active-high reset, overrides every transition
//   State_Sel : execute-entry state from the instruction encoder (0 = none)
//   MOC       : memory operation complete, sampled only in memory wait states
//   Cond      : ALU zero flag, consulted by BEQ
//   State     : current state number
//   PC_Ld, IR_Ld, MAR_Ld, MDR_Ld, RF_Ld : register load enables
//   MOV, RW   : memory request and direction (1 = read)
//   ALU_Op    : ALU operation select; Imm_Sel : ALU B from immediate
//   Illegal   : one-cycle pulse for an unrecognised instruction
// -----------------------------------------------------------------------------
module control_unit_fsm
  import control_unit_fsm_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic [STATE_W-1:0] State_Sel,
  input  logic               MOC,
  input  logic               Cond,
  output logic [STATE_W-1:0] State,
  output logic               PC_Ld,
  output logic               IR_Ld,
  output logic               MAR_Ld,
  output logic               MDR_Ld,
  output logic               RF_Ld,
  output logic               MOV,
  output logic               RW,
  output logic [ALU_W-1:0]   ALU_Op,
  output logic               Imm_Sel,
  output logic               Illegal
);

  state_e     state_q;
  state_e     state_d;
  ctrl_word_t ctrl;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_RESET;
    case (state_q)
      ST_RESET:    state_d = ST_FETCH0;
      ST_FETCH0:   state_d = ST_FETCH1;
      ST_FETCH1:   state_d = MOC ? ST_FETCH2 : ST_FETCH1;
      ST_FETCH2:   state_d = ST_DECODE;
      // State_Sel only matters here; unrecognised codes trap to ILLEGAL.
      ST_DECODE:   state_d = is_exec_entry(State_Sel) ? state_e'(State_Sel)
                                                      : ST_ILLEGAL;
      ST_ILLEGAL:  state_d = ST_FETCH0;
      ST_ADDU, ST_SUBU, ST_ADDIU, ST_SLTU, ST_SLTIU,
      ST_CLO, ST_CLZ, ST_AND, ST_ANDI:
                   state_d = ST_FETCH0;
      ST_SW_ADDR:  state_d = ST_SW_DATA;
      ST_SW_DATA:  state_d = ST_SW_MEM;
      ST_SW_MEM:   state_d = MOC ? ST_FETCH0 : ST_SW_MEM;
      ST_LW_ADDR:  state_d = ST_LW_MEM;
      ST_LW_MEM:   state_d = MOC ? ST_LW_WB : ST_LW_MEM;
      ST_LW_WB:    state_d = ST_FETCH0;
      ST_BEQ:      state_d = Cond ? ST_BEQ_TAKE : ST_FETCH0;
      ST_BEQ_TAKE: state_d = ST_FETCH0;
      // Unused codes (10, 16, 25..127) recover through RESET.
      default:     state_d = ST_RESET;
    endcase
  end

  control_rom u_control_rom (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  assign State   = state_q;
  assign PC_Ld   = ctrl.pc_ld;
  assign IR_Ld   = ctrl.ir_ld;
  assign MAR_Ld  = ctrl.mar_ld;
  assign MDR_Ld  = ctrl.mdr_ld;
  assign RF_Ld   = ctrl.rf_ld;
  assign MOV     = ctrl.mov;
  assign RW      = ctrl.rw;
  assign ALU_Op  = ctrl.alu_op;
  assign Imm_Sel = ctrl.imm_sel;
  assign Illegal = ctrl.illegal;

endmodule

// File: tb/tb_control_unit_fsm.sv
// -----------------------------------------------------------------------------
// tb_control_unit_fsm
// Directed scenarios plus randomized back-to-back instructions for
// control_unit_fsm. Expected states come from a per-instruction sequence
// builder; expected outputs come from per-signal state membership rules.
// -----------------------------------------------------------------------------
module tb_control_unit_fsm;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [6:0] State_Sel = '0;
  logic       MOC = 1'b0;
  logic       Cond = 1'b0;
  logic [6:0] State;
  logic       PC_Ld, IR_Ld, MAR_Ld, MDR_Ld, RF_Ld, MOV, RW;
  logic [3:0] ALU_Op;
  logic       Imm_Sel, Illegal;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  control_unit_fsm dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .State_Sel (State_Sel),
    .MOC       (MOC),
    .Cond      (Cond),
    .State     (State),
    .PC_Ld     (PC_Ld),
    .IR_Ld     (IR_Ld),
    .MAR_Ld    (MAR_Ld),
    .MDR_Ld    (MDR_Ld),
    .RF_Ld     (RF_Ld),
    .MOV       (MOV),
    .RW        (RW),
    .ALU_Op    (ALU_Op),
    .Imm_Sel   (Imm_Sel),
    .Illegal   (Illegal)
  );

  logic [12:0] obs;
  assign obs = {PC_Ld, IR_Ld, MAR_Ld, MDR_Ld, RF_Ld, MOV, RW, ALU_Op, Imm_Sel, Illegal};

  // Expected outputs for a state, one rule per signal.
  function automatic logic [12:0] exp_outs(input int s);
    logic pc, ir, mar, mdr, rf, mov, rw, imm, ill;
    logic [3:0] alu;
    pc  = (s == 3) || (s == 12);
    ir  = (s == 3);
    mar = (s == 1) || (s == 7) || (s == 13);
    mdr = (s == 2) || (s == 8) || (s == 14);
    rf  = (s == 6) || (s == 15) || (s >= 17 && s <= 24);
    mov = (s == 2) || (s == 9) || (s == 14);
    rw  = (s == 2) || (s == 14);
    imm = (s == 7) || (s == 13) || (s == 18) || (s == 20) || (s == 24);
    ill = (s == 5);
    if (s == 1)                    alu = 4'd6;
    else if (s == 11 || s == 17)   alu = 4'd1;
    else if (s == 19 || s == 20)   alu = 4'd3;
    else if (s == 21)              alu = 4'd4;
    else if (s == 22)              alu = 4'd5;
    else if (s == 23 || s == 24)   alu = 4'd2;
    else                           alu = 4'd0;
    return {pc, ir, mar, mdr, rf, mov, rw, alu, imm, ill};
  endfunction

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1; MOC = 1'b1; State_Sel = 7'd6; Cond = 1'b1;
    tick();
    tick();
    checks++;
    if (State !== 7'd0 || obs !== 13'd0) begin
      errors++;
      $display("FAIL reset_state: got state=%0d outs=%h, want state=0 outs=0000", State, obs);
    end else $display("reset_state: state=%0d outs=%h", State, obs);
    Reset = 1'b0;
    tick();
    checks++;
    if (State !== 7'd1 || obs !== exp_outs(1)) begin
      errors++;
      $display("FAIL reset_release: got state=%0d outs=%h, want state=1 outs=%h", State, obs, exp_outs(1));
    end else $display("reset_release: state=%0d", State);
  endtask

  task automatic test_addu();
    int st[7] = '{0, 1, 2, 3, 4, 6, 1};
    State_Sel = 7'd6; MOC = 1'b1; Cond = 1'b0;
    Reset = 1'b1; tick(); Reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (State !== 7'(st[i]) || obs !== exp_outs(st[i])) begin
        errors++;
        $display("FAIL addu step%0d: got state=%0d outs=%h, want state=%0d outs=%h", i, State, obs, st[i], exp_outs(st[i]));
      end else $display("addu step%0d: state=%0d outs=%h", i, State, obs);
      tick();
    end
  endtask

  task automatic test_lw_wait();
    int st[12] = '{0, 1, 2, 3, 4, 13, 14, 14, 14, 14, 15, 1};
    bit mc[12] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    State_Sel = 7'd13; Cond = 1'b0;
    Reset = 1'b1; tick(); Reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (State !== 7'(st[i]) || obs !== exp_outs(st[i])) begin
        errors++;
        $display("FAIL lw step%0d: got state=%0d outs=%h, want state=%0d outs=%h", i, State, obs, st[i], exp_outs(st[i]));
      end else $display("lw step%0d: state=%0d outs=%h", i, State, obs);
      MOC = mc[i];
      tick();
    end
  endtask

  task automatic test_beq();
    int st1[8] = '{0, 1, 2, 3, 4, 11, 12, 1};
    int st0[7] = '{0, 1, 2, 3, 4, 11, 1};
    State_Sel = 7'd11; MOC = 1'b1; Cond = 1'b1;
    Reset = 1'b1; tick(); Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (State !== 7'(st1[i]) || obs !== exp_outs(st1[i])) begin
        errors++;
        $display("FAIL beq_taken step%0d: got state=%0d outs=%h, want state=%0d outs=%h", i, State, obs, st1[i], exp_outs(st1[i]));
      end else $display("beq_taken step%0d: state=%0d outs=%h", i, State, obs);
      tick();
    end
    Cond = 1'b0;
    Reset = 1'b1; tick(); Reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (State !== 7'(st0[i]) || obs !== exp_outs(st0[i])) begin
        errors++;
        $display("FAIL beq_not_taken step%0d: got state=%0d outs=%h, want state=%0d outs=%h", i, State, obs, st0[i], exp_outs(st0[i]));
      end else $display("beq_not_taken step%0d: state=%0d outs=%h", i, State, obs);
      tick();
    end
  endtask

  task automatic test_illegal();
    int st[7] = '{0, 1, 2, 3, 4, 5, 1};
    int bad[3] = '{0, 10, 25};
    MOC = 1'b1; Cond = 1'b0;
    for (int k = 0; k < 3; k++) begin
      State_Sel = 7'(bad[k]);
      Reset = 1'b1; tick(); Reset = 1'b0;
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (State !== 7'(st[i]) || obs !== exp_outs(st[i])) begin
          errors++;
          $display("FAIL illegal sel=%0d step%0d: got state=%0d outs=%h, want state=%0d outs=%h", bad[k], i, State, obs, st[i], exp_outs(st[i]));
        end else $display("illegal sel=%0d step%0d: state=%0d Illegal=%0b", bad[k], i, State, Illegal);
        tick();
      end
    end
  endtask

  task automatic test_reset_mid_store();
    int st[9] = '{0, 1, 2, 3, 4, 7, 8, 9, 9};
    bit mc[9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    State_Sel = 7'd7; Cond = 1'b0;
    Reset = 1'b1; tick(); Reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (State !== 7'(st[i]) || obs !== exp_outs(st[i])) begin
        errors++;
        $display("FAIL sw_wait step%0d: got state=%0d outs=%h, want state=%0d outs=%h", i, State, obs, st[i], exp_outs(st[i]));
      end else $display("sw_wait step%0d: state=%0d outs=%h", i, State, obs);
      MOC = mc[i];
      tick();
    end
    // Still waiting in 9 with MOV=1; reset must win even with MOC high.
    Reset = 1'b1; MOC = 1'b1;
    tick();
    checks++;
    if (State !== 7'd0 || MOV !== 1'b0 || RW !== 1'b0 || obs !== 13'd0) begin
      errors++;
      $display("FAIL reset_in_wait: got state=%0d MOV=%0b RW=%0b outs=%h, want state=0 MOV=0 RW=0 outs=0000", State, MOV, RW, obs);
    end else $display("reset_in_wait: state=%0d MOV=%0b RW=%0b", State, MOV, RW);
    Reset = 1'b0;
    tick();
    checks++;
    if (State !== 7'd1) begin
      errors++;
      $display("FAIL reset_in_wait_release: got state=%0d, want state=1", State);
    end else $display("reset_in_wait_release: state=%0d", State);
  endtask

  task automatic test_sw_moc_early();
    int st[9] = '{0, 1, 2, 3, 4, 7, 8, 9, 1};
    State_Sel = 7'd7; MOC = 1'b1; Cond = 1'b0;
    Reset = 1'b1; tick(); Reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (State !== 7'(st[i]) || obs !== exp_outs(st[i])) begin
        errors++;
        $display("FAIL sw_early step%0d: got state=%0d outs=%h, want state=%0d outs=%h", i, State, obs, st[i], exp_outs(st[i]));
      end else $display("sw_early step%0d: state=%0d RW=%0b", i, State, RW);
      tick();
    end
  endtask

  typedef struct {
    int st;
    bit moc;
  } step_t;

  // Random instruction stream; each instruction's expected state trace is
  // built from the instruction class and the chosen memory latencies.
  task automatic test_back_to_back();
    int valid[12] = '{6, 7, 11, 13, 17, 18, 19, 20, 21, 22, 23, 24};
    step_t q[$];
    int sel, fd, md;
    bit cnd;
    Reset = 1'b1; tick(); Reset = 1'b0; tick();
    for (int n = 0; n < 60; n++) begin
      q.delete();
      if ($urandom_range(0, 3) != 0) sel = valid[$urandom_range(0, 11)];
      else sel = int'($urandom_range(0, 127));
      cnd = 1'($urandom);
      fd  = int'($urandom_range(0, 3));
      md  = int'($urandom_range(0, 3));
      q.push_back('{1, 1'($urandom)});
      for (int k = 0; k < fd; k++) q.push_back('{2, 1'b0});
      q.push_back('{2, 1'b1});
      q.push_back('{3, 1'($urandom)});
      q.push_back('{4, 1'($urandom)});
      if (sel == 7) begin
        q.push_back('{7, 1'($urandom)});
        q.push_back('{8, 1'($urandom)});
        for (int k = 0; k < md; k++) q.push_back('{9, 1'b0});
        q.push_back('{9, 1'b1});
      end else if (sel == 13) begin
        q.push_back('{13, 1'($urandom)});
        for (int k = 0; k < md; k++) q.push_back('{14, 1'b0});
        q.push_back('{14, 1'b1});
        q.push_back('{15, 1'($urandom)});
      end else if (sel == 11) begin
        q.push_back('{11, 1'($urandom)});
        if (cnd) q.push_back('{12, 1'($urandom)});
      end else if (sel == 6 || (sel >= 17 && sel <= 24)) begin
        q.push_back('{sel, 1'($urandom)});
      end else begin
        q.push_back('{5, 1'($urandom)});
      end
      foreach (q[i]) begin
        checks++;
        if (State !== 7'(q[i].st) || obs !== exp_outs(q[i].st)) begin
          errors++;
          $display("FAIL rand instr%0d sel=%0d step%0d: got state=%0d outs=%h, want state=%0d outs=%h",
                   n, sel, i, State, obs, q[i].st, exp_outs(q[i].st));
        end
        MOC       = q[i].moc;
        State_Sel = (q[i].st == 4) ? 7'(sel) : 7'($urandom);
        Cond      = (q[i].st == 11) ? cnd : 1'($urandom);
        tick();
      end
      $display("rand instr%0d: sel=%0d cond=%0b fetch_wait=%0d mem_wait=%0d steps=%0d", n, sel, cnd, fd, md, q.size());
    end
    checks++;
    if (State !== 7'd1) begin
      errors++;
      $display("FAIL rand_end: got state=%0d, want state=1", State);
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_reset_mid_store();
    test_sw_moc_early();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
